// File: rtl/coh_bus_ctrl_pkg.sv
// Shared types for the two-core snoopy coherence bus controller.
package coh_bus_ctrl_pkg;

  typedef enum logic [1:0] {BUS_NONE, BUS_RD, BUS_RFO, BUS_INV} bus_op_t;

  typedef enum logic [1:0] {DS_NONE, DS_MEM, DS_OTHER} datasel_t;

  typedef enum logic [2:0] {IDLE, INV, SNOOP, SNOOP_RSP, XFER, MEM} cbus_state_t;

  // Per-core request priority: write_miss > read_miss > invalidate.
  function automatic bus_op_t decode_op(input logic wm, input logic rm, input logic inv);
    if (wm)       return BUS_RFO;
    else if (rm)  return BUS_RD;
    else if (inv) return BUS_INV;
    else          return BUS_NONE;
  endfunction

endpackage

// File: rtl/coh_bus_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; rr_ptr names the core that wins a collision.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] win
);

  logic rr_ptr;

  always_comb begin
    win = req;
    if (req == 2'b11) win = rr_ptr ? 2'b10 : 2'b01;
  end

  // Pointer moves only on a collision, to the core that lost it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rr_ptr <= 1'b0;
    else if (adv && req == 2'b11)  rr_ptr <= ~rr_ptr;
  end

endmodule

// File: rtl/coh_bus_ctrl.sv
// Snoopy coherence bus controller for two cores: arbitration, snoop,
// cache-to-cache or memory fill, invalidate forwarding and memory timeout.
module coh_bus_ctrl
  import coh_bus_ctrl_pkg::*;
#(
  parameter int unsigned NCPU        = 2,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       read_miss,
  input  logic [1:0]       write_miss,
  input  logic [1:0]       invalidate,
  input  logic [1:0][10:0] BICO,
  input  logic [1:0]       cpu_search_found,
  input  logic [1:0][15:0] send_other_proc_data,
  input  logic             u_rdy,
  output logic [1:0]       grant,
  output logic [1:0]       cpu_search,
  output logic [12:0]      BOCI,
  output logic [1:0][1:0]  cpu_datasel,
  output logic [1:0]       invalidate_from_other_cpu,
  output logic [15:0]      other_proc_data,
  output logic [10:0]      u_addr,
  output logic             u_re,
  output logic             bus_err
);

  localparam int unsigned IDW = $clog2(NCPU);
  localparam int unsigned CW  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  cbus_state_t    state, state_nxt;
  bus_op_t        op, win_op;
  logic [10:0]    addr;
  logic [IDW-1:0] req_id, oth_id, win_id;
  logic [CW-1:0]  cnt;
  logic [1:0]     req, win;
  logic           timed_out;

  assign req = write_miss | read_miss | invalidate;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .adv   (state == IDLE),
    .win   (win)
  );

  assign win_id    = IDW'(win == 2'b10);
  assign win_op    = decode_op(write_miss[win_id], read_miss[win_id], invalidate[win_id]);
  assign oth_id    = ~req_id;
  assign timed_out = (MEM_TIMEOUT != 0) && (cnt == CW'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_id <= '0;
      op     <= BUS_NONE;
      addr   <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req) begin
        req_id <= win_id;
        op     <= win_op;
        addr   <= BICO[win_id];
      end
      cnt <= (state == MEM) ? cnt + CW'(1) : '0;
    end
  end

  always_comb begin
    state_nxt                 = state;
    grant                     = '0;
    cpu_search                = '0;
    BOCI                      = '0;
    cpu_datasel               = '0;
    invalidate_from_other_cpu = '0;
    other_proc_data           = '0;
    u_addr                    = '0;
    u_re                      = 1'b0;
    bus_err                   = 1'b0;

    if (state != IDLE) BOCI = {op, addr};

    case (state)
      IDLE: begin
        if (|req) state_nxt = (win_op == BUS_INV) ? INV : SNOOP;
      end
      INV: begin
        invalidate_from_other_cpu[oth_id] = 1'b1;
        grant[req_id]                     = 1'b1;
        state_nxt                         = IDLE;
      end
      SNOOP: begin
        cpu_search[oth_id] = 1'b1;
        state_nxt          = SNOOP_RSP;
      end
      SNOOP_RSP: begin
        state_nxt = cpu_search_found[oth_id] ? XFER : MEM;
      end
      XFER: begin
        other_proc_data                   = send_other_proc_data[oth_id];
        cpu_datasel[req_id]               = DS_OTHER;
        grant[req_id]                     = 1'b1;
        invalidate_from_other_cpu[oth_id] = (op == BUS_RFO);
        state_nxt                         = IDLE;
      end
      MEM: begin
        // A completion arriving on the timeout cycle takes precedence.
        if (u_rdy) begin
          u_re                              = 1'b1;
          u_addr                            = addr;
          cpu_datasel[req_id]               = DS_MEM;
          grant[req_id]                     = 1'b1;
          invalidate_from_other_cpu[oth_id] = (op == BUS_RFO);
          state_nxt                         = IDLE;
        end else if (timed_out) begin
          grant[req_id] = 1'b1;
          bus_err       = 1'b1;
          state_nxt     = IDLE;
        end else begin
          u_re   = 1'b1;
          u_addr = addr;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coh_bus_ctrl.sv
// Self-checking bench for coh_bus_ctrl: directed scenarios plus randomized
// transactions against a transaction-timeline reference model.
module tb_coh_bus_ctrl;

  localparam int TO = 4;
  localparam logic [1:0] OP_RD = 2'd1, OP_RFO = 2'd2, OP_INV = 2'd3;
  localparam logic [1:0] SEL_MEM = 2'd1, SEL_OTHER = 2'd2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       read_miss = '0, write_miss = '0, invalidate = '0;
  logic [1:0][10:0] BICO = '0;
  logic [1:0]       cpu_search_found = '0;
  logic [1:0][15:0] send_other_proc_data = '0;
  logic             u_rdy = 1'b0;
  logic [1:0]       grant, cpu_search, invalidate_from_other_cpu;
  logic [12:0]      BOCI;
  logic [1:0][1:0]  cpu_datasel;
  logic [15:0]      other_proc_data;
  logic [10:0]      u_addr;
  logic             u_re, bus_err;

  int checks = 0;
  int failures = 0;
  int rr = 0;

  coh_bus_ctrl #(.NCPU(2), .MEM_TIMEOUT(TO)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .read_miss                 (read_miss),
    .write_miss                (write_miss),
    .invalidate                (invalidate),
    .BICO                      (BICO),
    .cpu_search_found          (cpu_search_found),
    .send_other_proc_data      (send_other_proc_data),
    .u_rdy                     (u_rdy),
    .grant                     (grant),
    .cpu_search                (cpu_search),
    .BOCI                      (BOCI),
    .cpu_datasel               (cpu_datasel),
    .invalidate_from_other_cpu (invalidate_from_other_cpu),
    .other_proc_data           (other_proc_data),
    .u_addr                    (u_addr),
    .u_re                      (u_re),
    .bus_err                   (bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [51:0] obs();
    return {grant, cpu_search, BOCI, cpu_datasel, invalidate_from_other_cpu,
            other_proc_data, u_addr, u_re, bus_err};
  endfunction

  task automatic chk(input string tag, input logic [51:0] got, input logic [51:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs k cycles after the latch edge of one transaction.
  function automatic logic [51:0] model(input int w, input logic [1:0] op, input logic [10:0] addr,
                                        input int k, input bit found, input logic [15:0] data,
                                        input int rdy, output bit done);
    logic [1:0] g, s, io;
    logic [1:0][1:0] ds;
    logic [15:0] pd;
    logic [10:0] ua;
    logic re, be;
    int o, m;
    o = 1 - w;
    g = '0; s = '0; io = '0; ds = '0; pd = '0; ua = '0; re = 1'b0; be = 1'b0; done = 1'b0;
    if (op == OP_INV) begin
      if (k == 1) begin io[o] = 1'b1; g[w] = 1'b1; done = 1'b1; end
    end else if (k == 1) begin
      s[o] = 1'b1;
    end else if (k >= 3) begin
      if (found) begin
        pd = data; ds[w] = SEL_OTHER; g[w] = 1'b1; io[o] = (op == OP_RFO); done = 1'b1;
      end else begin
        m = k - 3;
        if (m == rdy) begin
          re = 1'b1; ua = addr; ds[w] = SEL_MEM; g[w] = 1'b1; io[o] = (op == OP_RFO); done = 1'b1;
        end else if (TO != 0 && m == TO) begin
          g[w] = 1'b1; be = 1'b1; done = 1'b1;
        end else begin
          re = 1'b1; ua = addr;
        end
      end
    end
    return {g, s, op, addr, ds, io, pd, ua, re, be};
  endfunction

  task automatic set_req(input int w, input logic [1:0] op, input logic [10:0] addr,
                         input bit found, input logic [15:0] data);
    BICO[w] = addr;
    cpu_search_found[1-w] = found;
    send_other_proc_data[1-w] = data;
    case (op)
      OP_RFO:  write_miss[w] = 1'b1;
      OP_RD:   read_miss[w]  = 1'b1;
      default: invalidate[w] = 1'b1;
    endcase
  endtask

  // Follows one transaction from its latch edge through grant and the idle cycle after.
  task automatic run_txn(input int w, input logic [1:0] op, input logic [10:0] addr,
                         input bit found, input logic [15:0] data, input int rdy, input string tag);
    bit done;
    bit in_mem;
    int k;
    logic [51:0] exp;
    done = 1'b0;
    k = 0;
    while (!done && k < TO + 8) begin
      k++;
      @(posedge clk); #2;
      if (k == 1) begin read_miss[w] = 1'b0; write_miss[w] = 1'b0; invalidate[w] = 1'b0; end
      in_mem = (op != OP_INV) && !found && k >= 3;
      u_rdy = in_mem ? (k - 3 == rdy) : 1'($urandom_range(1, 0));
      #1;
      exp = model(w, op, addr, k, found, data, rdy, done);
      chk($sformatf("%s_k%0d", tag, k), obs(), exp);
    end
    @(posedge clk); #2;
    u_rdy = 1'($urandom_range(1, 0));
    #1;
    chk($sformatf("%s_idle", tag), obs(), '0);
    u_rdy = 1'b0;
  endtask

  task automatic collide(input logic [10:0] a0, input logic [10:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1, input string tag);
    int w;
    BICO[0] = a0; BICO[1] = a1;
    cpu_search_found = 2'b11;
    send_other_proc_data[0] = d0; send_other_proc_data[1] = d1;
    read_miss = 2'b11;
    w = rr;
    rr = 1 - rr;
    if (w == 0) begin
      run_txn(0, OP_RD, a0, 1'b1, d1, -1, {tag, "_c0"});
      run_txn(1, OP_RD, a1, 1'b1, d0, -1, {tag, "_c1"});
    end else begin
      run_txn(1, OP_RD, a1, 1'b1, d0, -1, {tag, "_c1"});
      run_txn(0, OP_RD, a0, 1'b1, d1, -1, {tag, "_c0"});
    end
  endtask

  initial begin
    int w, rdy;
    logic [2:0] bits;
    logic [1:0] op;
    logic [10:0] addr;
    logic [15:0] data;
    bit found;

    repeat (2) @(posedge clk);
    #3 chk("reset", obs(), '0);
    @(negedge clk) rst_n = 1'b1;

    @(negedge clk);
    set_req(0, OP_INV, 11'h123, 1'b0, 16'h0);
    run_txn(0, OP_INV, 11'h123, 1'b0, 16'h0, -1, "t1_inv");

    @(negedge clk);
    set_req(1, OP_RD, 11'h040, 1'b1, 16'hBEEF);
    run_txn(1, OP_RD, 11'h040, 1'b1, 16'hBEEF, -1, "t2_xfer");

    @(negedge clk);
    set_req(0, OP_RFO, 11'h7FF, 1'b0, 16'h5A5A);
    run_txn(0, OP_RFO, 11'h7FF, 1'b0, 16'h5A5A, 4, "t3_mem");

    @(negedge clk);
    set_req(1, OP_RD, 11'h2A5, 1'b0, 16'h1234);
    run_txn(1, OP_RD, 11'h2A5, 1'b0, 16'h1234, 1, "t3b_mem");

    rr = 0;
    @(negedge clk);
    collide(11'h011, 11'h022, 16'h1111, 16'h2222, "t4a");
    collide(11'h033, 11'h044, 16'h3333, 16'h4444, "t4b");

    @(negedge clk);
    set_req(1, OP_RD, 11'h155, 1'b0, 16'h0);
    run_txn(1, OP_RD, 11'h155, 1'b0, 16'h0, -1, "t5_timeout");
    @(negedge clk);
    set_req(0, OP_RFO, 11'h156, 1'b0, 16'h0);
    run_txn(0, OP_RFO, 11'h156, 1'b0, 16'h0, TO, "t5_rdy_on_to");

    // Reset while the memory read is outstanding.
    @(negedge clk);
    set_req(0, OP_RD, 11'h3C3, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #2 read_miss = '0;
    #1 chk("t6_in_mem", obs(), {2'b00, 2'b00, OP_RD, 11'h3C3, 4'h0, 2'b00, 16'h0, 11'h3C3, 1'b1, 1'b0});
    rst_n = 1'b0;
    #1 chk("t6_async_rst", obs(), '0);
    @(negedge clk) rst_n = 1'b1;
    rr = 0;
    u_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      chk($sformatf("t6_no_grant_%0d", i), obs(), '0);
    end
    u_rdy = 1'b0;
    @(negedge clk);
    set_req(0, OP_RD, 11'h0F0, 1'b1, 16'hCAFE);
    run_txn(0, OP_RD, 11'h0F0, 1'b1, 16'hCAFE, -1, "t6_after");

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(1, 0)) @(negedge clk);
      w     = int'($urandom_range(1, 0));
      bits  = 3'($urandom_range(7, 1));
      addr  = 11'($urandom);
      data  = 16'($urandom);
      found = 1'($urandom_range(1, 0));
      rdy   = int'($urandom_range(7, 0)) - 1;
      op    = bits[2] ? OP_RFO : (bits[1] ? OP_RD : OP_INV);
      BICO[1-w] = 11'($urandom);
      cpu_search_found[w] = 1'($urandom_range(1, 0));
      send_other_proc_data[w] = 16'($urandom);
      BICO[w] = addr;
      cpu_search_found[1-w] = found;
      send_other_proc_data[1-w] = data;
      write_miss[w] = bits[2];
      read_miss[w]  = bits[1];
      invalidate[w] = bits[0];
      run_txn(w, op, addr, found, data, rdy, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
